// File: rtl/step_seq_pkg.sv
// Shared definitions for the step sequencer and the control-signal decoder:
// FSM state encoding and the default step geometry.
package step_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_RUN    = 2'b01,
      ST_HALTED = 2'b10
   } seq_state_t;

   localparam int DEF_STEPS   = 5;
   localparam int DEF_COUNT_W = 3;

endpackage : step_seq_pkg

// File: rtl/instr_counter.sv
// Wrapping completed-instruction counter with synchronous reset and
// increment enable; rolls from all-ones to zero silently.
module instr_counter #(
   parameter int W = 16
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_inc,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_count <= '0;
      end else if (i_inc) begin
         r_count <= r_count + W'(1);
      end
   end

   assign o_count = r_count;

endmodule : instr_counter

// File: rtl/step_sequencer.sv
// Multicycle step sequencer: produces the per-instruction step number 1..STEPS
// with stall, early end, step load, halt/start control and an instruction count.
//
// Handshake: there is no valid/ready pair here; i_enable acts as a one-sided
// advance qualifier sampled on every rising edge while in RUN, and o_instr_done
// is a single-cycle registered pulse with no back-pressure.
module step_sequencer
   import step_seq_pkg::*;
#(
   parameter int STEPS   = DEF_STEPS,
   parameter int COUNT_W = DEF_COUNT_W,
   parameter int INSTR_W = 16
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_start,
   input  logic               i_enable,
   input  logic               i_end_early,
   input  logic               i_halt_req,
   input  logic               i_load_en,
   input  logic [COUNT_W-1:0] i_load_step,
   output logic [COUNT_W-1:0] o_clock_count,
   output logic [STEPS-1:0]   o_step_one_hot,
   output logic               o_last_step,
   output logic               o_running,
   output logic               o_instr_done,
   output logic [INSTR_W-1:0] o_instr_count,
   output seq_state_t         o_dbg_state
);

   localparam logic [COUNT_W-1:0] STEP_ONE  = COUNT_W'(1);
   localparam logic [COUNT_W-1:0] STEP_LAST = COUNT_W'(STEPS);

   seq_state_t         r_state;
   seq_state_t         w_next_state;
   logic [COUNT_W-1:0] r_count;
   logic [COUNT_W-1:0] w_next_count;
   logic [COUNT_W-1:0] w_load_value;
   logic               r_done;
   logic               w_done;
   logic               w_end_of_instr;
   logic [STEPS-1:0]   w_one_hot;

   // Out-of-range load targets fall back to the first step.
   assign w_load_value   = ((i_load_step != '0) && (i_load_step <= STEP_LAST)) ?
                           i_load_step : STEP_ONE;
   assign w_end_of_instr = (r_count == STEP_LAST) || i_end_early;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
         r_count <= STEP_ONE;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_count <= w_next_count;
         r_done  <= w_done;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_next_count = r_count;
      w_done       = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (i_enable) begin
               if (i_load_en) begin
                  w_next_count = w_load_value;
               end else if (w_end_of_instr) begin
                  w_next_count = STEP_ONE;
                  w_done       = 1'b1;
                  if (i_halt_req) begin
                     w_next_state = ST_HALTED;
                  end
               end else begin
                  w_next_count = r_count + STEP_ONE;
               end
            end
         end
         default: begin
            w_next_count = STEP_ONE;
            if (i_start) begin
               w_next_state = ST_RUN;
            end
         end
      endcase
   end

   // The completion counter shares the reset, so a completion in a reset cycle is dropped.
   instr_counter #(
      .W(INSTR_W)
   ) u_instr_counter (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_inc   (w_done),
      .o_count (o_instr_count)
   );

   always_comb begin
      w_one_hot = '0;
      for (int i = 0; i < STEPS; i++) begin
         w_one_hot[i] = (r_count == COUNT_W'(i + 1));
      end
      if (r_state != ST_RUN) begin
         w_one_hot = STEPS'(1);
      end
   end

   assign o_clock_count  = r_count;
   assign o_step_one_hot = w_one_hot;
   assign o_last_step    = (r_count == STEP_LAST);
   assign o_running      = (r_state == ST_RUN);
   assign o_instr_done   = r_done;
   assign o_dbg_state    = r_state;

endmodule : step_sequencer

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer: a 5-step instance for control behaviour
// and a 2-step / 4-bit-count instance for alternation and count wrap.
module tb_step_sequencer;
   import step_seq_pkg::*;

   typedef struct {
      logic [2:0]  cnt;
      logic        done;
      logic [15:0] ic;
      seq_state_t  st;
   } exp_t;

   exp_t exp_q[$];
   exp_t exp2_q[$];

   int checks   = 0;
   int failures = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 5-step instance
   logic       rst1, st1, en1, ee1, hr1, ld1;
   logic [2:0] ls1;
   logic [2:0] cc1;
   logic [4:0] oh1;
   logic       last1, run1, done1;
   logic [15:0] ic1;
   seq_state_t  dst1;

   // 2-step instance
   logic       rst2, st2, en2, ee2, hr2, ld2;
   logic [1:0] ls2;
   logic [1:0] cc2;
   logic [1:0] oh2;
   logic       last2, run2, done2;
   logic [3:0] ic2;
   seq_state_t dst2;

   step_sequencer #(.STEPS(5), .COUNT_W(3), .INSTR_W(16)) dut1 (
      .i_clk(clk), .i_reset(rst1), .i_start(st1), .i_enable(en1),
      .i_end_early(ee1), .i_halt_req(hr1), .i_load_en(ld1), .i_load_step(ls1),
      .o_clock_count(cc1), .o_step_one_hot(oh1), .o_last_step(last1),
      .o_running(run1), .o_instr_done(done1), .o_instr_count(ic1),
      .o_dbg_state(dst1)
   );

   step_sequencer #(.STEPS(2), .COUNT_W(2), .INSTR_W(4)) dut2 (
      .i_clk(clk), .i_reset(rst2), .i_start(st2), .i_enable(en2),
      .i_end_early(ee2), .i_halt_req(hr2), .i_load_en(ld2), .i_load_step(ls2),
      .o_clock_count(cc2), .o_step_one_hot(oh2), .o_last_step(last2),
      .o_running(run2), .o_instr_done(done2), .o_instr_count(ic2),
      .o_dbg_state(dst2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step1(input logic rst, input logic st, input logic en, input logic ee,
                        input logic hr, input logic ld, input logic [2:0] ls,
                        input logic [2:0] e_cnt, input logic e_done, input logic [15:0] e_ic,
                        input seq_state_t e_st, input string tag);
      exp_t e;
      logic [4:0] e_oh;
      rst1 = rst; st1 = st; en1 = en; ee1 = ee; hr1 = hr; ld1 = ld; ls1 = ls;
      exp_q.push_back('{cnt: e_cnt, done: e_done, ic: e_ic, st: e_st});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      e_oh = (e.st == ST_RUN) ? (5'b00001 << (e.cnt - 3'd1)) : 5'b00001;
      chk({tag, ".count"},   32'(cc1),   32'(e.cnt));
      chk({tag, ".onehot"},  32'(oh1),   32'(e_oh));
      chk({tag, ".last"},    32'(last1), 32'(e.cnt == 3'd5));
      chk({tag, ".running"}, 32'(run1),  32'(e.st == ST_RUN));
      chk({tag, ".done"},    32'(done1), 32'(e.done));
      chk({tag, ".icount"},  32'(ic1),   32'(e.ic));
      chk({tag, ".state"},   32'(dst1),  32'(e.st));
   endtask

   task automatic step2(input logic rst, input logic st, input logic en,
                        input logic [1:0] e_cnt, input logic e_done, input logic [3:0] e_ic,
                        input seq_state_t e_st, input string tag);
      exp_t e;
      st2 = st; rst2 = rst; en2 = en;
      exp2_q.push_back('{cnt: 3'(e_cnt), done: e_done, ic: 16'(e_ic), st: e_st});
      @(posedge clk);
      #1;
      e = exp2_q.pop_front();
      chk({tag, ".count"},   32'(cc2),   32'(e.cnt));
      chk({tag, ".onehot"},  32'(oh2),   (e.st == ST_RUN && e.cnt == 3'd2) ? 32'd2 : 32'd1);
      chk({tag, ".last"},    32'(last2), 32'(e.cnt == 3'd2));
      chk({tag, ".done"},    32'(done2), 32'(e.done));
      chk({tag, ".icount"},  32'(ic2),   32'(e.ic));
      chk({tag, ".state"},   32'(dst2),  32'(e.st));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst1 = 1'b1; st1 = 0; en1 = 0; ee1 = 0; hr1 = 0; ld1 = 0; ls1 = '0;
      rst2 = 1'b1; st2 = 0; en2 = 0; ee2 = 0; hr2 = 0; ld2 = 0; ls2 = '0;
      #1;

      // Reset, then inputs ignored while idle
      step1(1,0,0,0,0,0,3'd0, 3'd1,0,16'd0,ST_IDLE,"reset");
      step1(0,0,1,1,1,1,3'd4, 3'd1,0,16'd0,ST_IDLE,"idle_ignore");
      step1(0,1,1,0,0,0,3'd0, 3'd1,0,16'd0,ST_RUN,"start");
      // Two full instructions; start held in RUN is ignored
      step1(0,1,1,0,0,0,3'd0, 3'd2,0,16'd0,ST_RUN,"run_a2");
      step1(0,0,1,0,0,0,3'd0, 3'd3,0,16'd0,ST_RUN,"run_a3");
      step1(0,0,1,0,0,0,3'd0, 3'd4,0,16'd0,ST_RUN,"run_a4");
      step1(0,0,1,0,0,0,3'd0, 3'd5,0,16'd0,ST_RUN,"run_a5");
      step1(0,0,1,0,0,0,3'd0, 3'd1,1,16'd1,ST_RUN,"run_a1");
      step1(0,0,1,0,0,0,3'd0, 3'd2,0,16'd1,ST_RUN,"run_b2");
      step1(0,0,1,0,0,0,3'd0, 3'd3,0,16'd1,ST_RUN,"run_b3");
      step1(0,0,1,0,0,0,3'd0, 3'd4,0,16'd1,ST_RUN,"run_b4");
      step1(0,0,1,0,0,0,3'd0, 3'd5,0,16'd1,ST_RUN,"run_b5");
      step1(0,0,1,0,0,0,3'd0, 3'd1,1,16'd2,ST_RUN,"run_b1");
      step1(0,0,1,0,0,0,3'd0, 3'd2,0,16'd2,ST_RUN,"run_c2");
      step1(0,0,1,0,0,0,3'd0, 3'd3,0,16'd2,ST_RUN,"run_c3");
      // Stall at step 3; stalled inputs must not act
      for (int i = 0; i < 4; i++)
         step1(0,0,0,1,1,1,3'd1, 3'd3,0,16'd2,ST_RUN,"stall");
      step1(0,0,1,0,0,0,3'd0, 3'd4,0,16'd2,ST_RUN,"resume4");
      step1(0,0,1,0,0,0,3'd0, 3'd5,0,16'd2,ST_RUN,"resume5");
      step1(0,0,1,0,0,0,3'd0, 3'd1,1,16'd3,ST_RUN,"resume1");
      step1(0,0,0,0,0,0,3'd0, 3'd1,0,16'd3,ST_RUN,"done_clr_stall");
      // Early end at step 2, then load overriding early end
      step1(0,0,1,0,0,0,3'd0, 3'd2,0,16'd3,ST_RUN,"ee_s2");
      step1(0,0,1,1,0,0,3'd0, 3'd1,1,16'd4,ST_RUN,"ee_end");
      step1(0,0,1,0,0,0,3'd0, 3'd2,0,16'd4,ST_RUN,"ld_s2");
      step1(0,0,1,1,0,1,3'd4, 3'd4,0,16'd4,ST_RUN,"ld_over_ee");
      step1(0,0,1,0,0,0,3'd0, 3'd5,0,16'd4,ST_RUN,"to5");
      // Halt at step 5; halted ignores everything but start
      step1(0,0,1,0,1,0,3'd0, 3'd1,1,16'd5,ST_HALTED,"halt");
      step1(0,0,1,1,1,1,3'd3, 3'd1,0,16'd5,ST_HALTED,"halted_ign");
      step1(0,1,0,0,0,0,3'd0, 3'd1,0,16'd5,ST_RUN,"restart");
      step1(0,0,1,0,0,0,3'd0, 3'd2,0,16'd5,ST_RUN,"rs2");
      // Halt request mid-instruction is not remembered
      step1(0,0,1,0,1,0,3'd0, 3'd3,0,16'd5,ST_RUN,"halt_mid");
      step1(0,0,1,0,0,0,3'd0, 3'd4,0,16'd5,ST_RUN,"rs4");
      step1(0,0,1,0,0,0,3'd0, 3'd5,0,16'd5,ST_RUN,"rs5");
      // Early end coinciding with last step counts once
      step1(0,0,1,1,0,0,3'd0, 3'd1,1,16'd6,ST_RUN,"ee_last");
      // Out-of-range loads
      step1(0,0,1,0,0,1,3'd0, 3'd1,0,16'd6,ST_RUN,"ld0");
      step1(0,0,1,0,0,0,3'd0, 3'd2,0,16'd6,ST_RUN,"ld_pre");
      step1(0,0,1,0,0,1,3'd7, 3'd1,0,16'd6,ST_RUN,"ld7");
      step1(0,0,1,0,0,1,3'd5, 3'd5,0,16'd6,ST_RUN,"ld5");
      step1(0,0,1,0,0,0,3'd0, 3'd1,1,16'd7,ST_RUN,"ld5_end");
      step1(0,0,1,0,0,0,3'd0, 3'd2,0,16'd7,ST_RUN,"p2");
      step1(0,0,1,0,0,0,3'd0, 3'd3,0,16'd7,ST_RUN,"p3");
      step1(0,0,1,0,0,0,3'd0, 3'd4,0,16'd7,ST_RUN,"p4");
      // Reset at step 4 with early end discards the completion
      step1(1,1,1,1,1,0,3'd0, 3'd1,0,16'd0,ST_IDLE,"reset_mid");
      step1(0,0,1,0,0,0,3'd0, 3'd1,0,16'd0,ST_IDLE,"post_reset");

      // Two-step instance: alternation and count wrap after 17 instructions
      step2(1,0,0, 2'd1,0,4'd0,ST_IDLE,"s2_reset");
      step2(0,1,1, 2'd1,0,4'd0,ST_RUN,"s2_start");
      for (int k = 1; k <= 34; k++) begin
         step2(0,0,1, (k % 2 == 1) ? 2'd2 : 2'd1, (k % 2 == 0), 4'((k / 2) % 16),
               ST_RUN, "s2_run");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_step_sequencer
